// File: rtl/mic1_shifter_if.sv
// mic1_shifter_if: shifter bus between the ALU side and the shifter.
//   master drives the ALU result and shift code and sees the registered word;
//   slave is the shifter itself.
interface mic1_shifter_if;
   logic [1:0]  control;   // shift code from the microinstruction
   logic [31:0] data;      // ALU result
   logic [31:0] dataOut;   // registered shifted word onto the C bus

   modport master (output control, output data, input  dataOut);
   modport slave  (input  control, input  data, output dataOut);
endinterface

// File: rtl/mic1_shifter.sv
// mic1_shifter: registered 32-bit shifter behind the MIC-1 ALU.
//   control 00 pass, 01 sign-preserving shift right 1, 10 shift left 8,
//   11 rotate left 8 when SHIFTER_ROT8_EN is defined, otherwise pass.
//   One clock of latency, no handshake; synchronous active-high reset.
// Build option: `define SHIFTER_ROT8_EN to enable the rotate on code 11.
module mic1_shifter (
   input  logic           clk,
   input  logic           reset,
   mic1_shifter_if.slave  bus
);

   logic [31:0] dataOut_d;
   logic [31:0] dataOut_q;

   // Shift function; 01 keeps the sign bit and shifts the 31-bit magnitude,
   // so bit 30 always becomes 0 rather than a copy of the sign.
   always_comb begin
      dataOut_d = bus.data;
      case (bus.control)
         2'b00:   dataOut_d = bus.data;
         2'b01:   dataOut_d = {bus.data[31], 1'b0, bus.data[30:1]};
         2'b10:   dataOut_d = {bus.data[23:0], 8'h00};
`ifdef SHIFTER_ROT8_EN
         2'b11:   dataOut_d = {bus.data[23:0], bus.data[31:24]};
`else
         2'b11:   dataOut_d = bus.data;
`endif
         default: dataOut_d = bus.data;
      endcase
   end

   // Output register; reset discards whatever result is in flight.
   always_ff @(posedge clk) begin
      if (reset) dataOut_q <= 32'h0000_0000;
      else       dataOut_q <= dataOut_d;
   end

   assign bus.dataOut = dataOut_q;

endmodule

// File: tb/tb_mic1_shifter.sv
// tb_mic1_shifter: directed plan vectors plus randomized traffic checked
// against an arithmetic reference model of the shift codes.
module tb_mic1_shifter;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   mic1_shifter_if bus ();

   mic1_shifter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report a mismatch.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Reference shift written as plain arithmetic on unsigned words.
   function automatic logic [31:0] model(input logic [1:0] c, input logic [31:0] d);
      logic [31:0] sign;
      sign = d & 32'h8000_0000;
      if (c == 2'd1) return sign | ((d & 32'h7FFF_FFFF) / 2);
      if (c == 2'd2) return d * 256;
`ifdef SHIFTER_ROT8_EN
      if (c == 2'd3) return (d * 256) | (d / 32'h0100_0000);
`endif
      return d;
   endfunction

   // Apply one vector, clock it, and check the registered result.
   task automatic step(input string tag, input logic rst, input logic [1:0] c,
                       input logic [31:0] d, input logic [31:0] exp);
      reset       = rst;
      bus.control = c;
      bus.data    = d;
      @(posedge clk);
      #1;
      chk(tag, bus.dataOut, exp);
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  c;
      logic        r;
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      bus.control = 2'b10;
      bus.data    = 32'hFFFF_FFFF;
      #1;

      // Reset held for two edges against nonzero inputs.
      step("rst0", 1'b1, 2'b10, 32'hFFFF_FFFF, 32'h0000_0000);
      step("rst1", 1'b1, 2'b10, 32'hFFFF_FFFF, 32'h0000_0000);
      step("rst_rel", 1'b0, 2'b00, 32'h0000_0000, 32'h0000_0000);

      // Sign-preserving right shift.
      step("sr_neg", 1'b0, 2'b01, 32'h8888_8888, 32'h8444_4444);
      step("sr_pos", 1'b0, 2'b01, 32'h7FFF_FFFF, 32'h3FFF_FFFF);

      // Pass and left shift.
      step("pass",  1'b0, 2'b00, 32'h1234_5678, 32'h1234_5678);
      step("shl8",  1'b0, 2'b10, 32'h1234_5678, 32'h3456_7800);
      step("shl8b", 1'b0, 2'b10, 32'hFF00_00FF, 32'h0000_FF00);

      // Code 11 depends on the build option.
`ifdef SHIFTER_ROT8_EN
      step("c11", 1'b0, 2'b11, 32'hAABB_CCDD, 32'hBBCC_DDAA);
`else
      step("c11", 1'b0, 2'b11, 32'hAABB_CCDD, 32'hAABB_CCDD);
`endif

      // Output holds between edges while inputs change.
      bus.control = 2'b10;
      bus.data    = 32'h0F0F_0F0F;
      #3;
      chk("hold", bus.dataOut, model(2'b11, 32'hAABB_CCDD));

      // Back-to-back codes, one result per edge.
      step("b2b0", 1'b0, 2'b00, 32'h8000_0001, 32'h8000_0001);
      step("b2b1", 1'b0, 2'b01, 32'h8000_0001, 32'h8000_0000);
      step("b2b2", 1'b0, 2'b10, 32'h8000_0001, 32'h0000_0100);

      // Reset mid-stream: result visible one cycle, then cleared.
      step("mid_pre", 1'b0, 2'b01, 32'h8888_8888, 32'h8444_4444);
      step("mid_rst", 1'b1, 2'b01, 32'h8888_8888, 32'h0000_0000);
      step("mid_rel", 1'b0, 2'b10, 32'h0000_00AB, 32'h0000_AB00);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 300; i++) begin
         d = $urandom;
         c = 2'($urandom_range(0, 3));
         r = ($urandom_range(0, 15) == 0);
         step("rand", r, c, d, r ? 32'h0000_0000 : model(c, d));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
